// File: rtl/mem_arb_pkg.sv
// Shared types and sizing helpers for the multi-channel memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Channel index width, never narrower than one bit.
  function automatic int ch_idx_bits(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Latency down-counter width; holds MEM_LATENCY-1 at most.
  function automatic int lat_cnt_bits(input int lat);
    return (lat <= 2) ? 1 : $clog2(lat);
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational winner selection: round-robin from ptr, or fixed lowest-index
// priority when MEM_ARB_FIXED_PRIO_EN is defined (ptr is then ignored).
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int IDX_W  = ch_idx_bits(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [IDX_W-1:0]  winner,
  output logic              any_req
);

`ifdef MEM_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    winner = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[i]) winner = IDX_W'(i);
    end
  end
`else
  // Lowest request at or above ptr wins; otherwise wrap to lowest overall.
  always_comb begin
    winner = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[i]) winner = IDX_W'(i);
    end
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[i] && (IDX_W'(i) >= ptr)) winner = IDX_W'(i);
    end
  end
`endif

  assign any_req = |req;

endmodule

// File: rtl/mem_arbiter.sv
// Multi-channel arbiter in front of one single-port synchronous memory.
// Optional build macro MEM_ARB_FIXED_PRIO_EN: fixed lowest-index priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int ADDR_BITS   = 16,
  parameter int NUM_CH      = 2,
  parameter int MEM_LATENCY = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_CH-1:0]              ch_req,
  input  logic [NUM_CH-1:0]              ch_we,
  input  logic [NUM_CH*ADDR_BITS-1:0]    ch_addr,
  input  logic [NUM_CH*WIDTH-1:0]        ch_wdata,
  output logic [NUM_CH-1:0]              ch_ack,
  output logic [WIDTH-1:0]               ch_rdata,
  output logic [ch_idx_bits(NUM_CH)-1:0] grant_idx,
  output logic                           busy,
  input  logic [WIDTH-1:0]               data_from_mem,
  output logic [ADDR_BITS-1:0]           mem_address,
  output logic [WIDTH-1:0]               data_to_mem_store,
  output logic                           write_to_memory,
  output logic                           reading_for_load
);

  localparam int IDX_W = ch_idx_bits(NUM_CH);
  localparam int CNT_W = lat_cnt_bits(MEM_LATENCY);

  state_t                 state;
  logic [IDX_W-1:0]       ptr;
  logic [IDX_W-1:0]       winner;
  logic                   any_req;
  logic [CNT_W-1:0]       cnt;
  logic                   we_lat;
  logic [ADDR_BITS-1:0]   addr_sel;
  logic [WIDTH-1:0]       wdata_sel;
  logic                   we_sel;

  rr_pick #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_pick (
    .req     (ch_req),
    .ptr     (ptr),
    .winner  (winner),
    .any_req (any_req)
  );

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`endif

  always_comb begin
    addr_sel  = '0;
    wdata_sel = '0;
    we_sel    = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (winner == IDX_W'(i)) begin
        addr_sel  = ch_addr[i*ADDR_BITS +: ADDR_BITS];
        wdata_sel = ch_wdata[i*WIDTH +: WIDTH];
        we_sel    = ch_we[i];
      end
    end
  end

  // Read data is passed straight through while the response cycle is up.
  assign ch_rdata = (state == RESP && !we_lat) ? data_from_mem : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      cnt               <= '0;
      we_lat            <= 1'b0;
      grant_idx         <= '0;
      mem_address       <= '0;
      data_to_mem_store <= '0;
      write_to_memory   <= 1'b0;
      reading_for_load  <= 1'b0;
      ch_ack            <= '0;
      busy              <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      ptr               <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state             <= ACCESS;
            cnt               <= CNT_W'(MEM_LATENCY - 1);
            we_lat            <= we_sel;
            grant_idx         <= winner;
            mem_address       <= addr_sel;
            data_to_mem_store <= wdata_sel;
            write_to_memory   <= we_sel;
            reading_for_load  <= ~we_sel;
            busy              <= 1'b1;
`ifndef MEM_ARB_FIXED_PRIO_EN
            ptr               <= (winner == IDX_W'(NUM_CH - 1)) ? '0 : winner + 1'b1;
`endif
          end
        end
        ACCESS: begin
          // Write strobe lives for the first access cycle only.
          write_to_memory <= 1'b0;
          if (cnt == '0) begin
            state            <= RESP;
            reading_for_load <= 1'b0;
            ch_ack           <= NUM_CH'(1) << grant_idx;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          state  <= IDLE;
          ch_ack <= '0;
          busy   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a 3-channel latency-1 instance plus a
// 3-channel latency-3 instance, each behind a small memory model.
module tb_mem_arbiter;

  localparam int W  = 16;
  localparam int AB = 16;
  localparam int N  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic mem_init;

  logic [N-1:0]    ch_req, ch_we, ch_ack;
  logic [N*AB-1:0] ch_addr;
  logic [N*W-1:0]  ch_wdata;
  logic [W-1:0]    ch_rdata, data_from_mem, data_to_mem_store;
  logic [1:0]      grant_idx;
  logic            busy, write_to_memory, reading_for_load;
  logic [AB-1:0]   mem_address;

  logic [N-1:0]    ch_req_l, ch_we_l, ch_ack_l;
  logic [N*AB-1:0] ch_addr_l;
  logic [N*W-1:0]  ch_wdata_l;
  logic [W-1:0]    ch_rdata_l, data_from_mem_l, data_to_mem_store_l, d1_l, d2_l;
  logic [1:0]      grant_idx_l;
  logic            busy_l, write_to_memory_l, reading_for_load_l;
  logic [AB-1:0]   mem_address_l;

  mem_arbiter #(.WIDTH(W), .ADDR_BITS(AB), .NUM_CH(N), .MEM_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .ch_req(ch_req), .ch_we(ch_we), .ch_addr(ch_addr),
    .ch_wdata(ch_wdata), .ch_ack(ch_ack), .ch_rdata(ch_rdata), .grant_idx(grant_idx),
    .busy(busy), .data_from_mem(data_from_mem), .mem_address(mem_address),
    .data_to_mem_store(data_to_mem_store), .write_to_memory(write_to_memory),
    .reading_for_load(reading_for_load)
  );

  mem_arbiter #(.WIDTH(W), .ADDR_BITS(AB), .NUM_CH(N), .MEM_LATENCY(3)) dut_l (
    .clk(clk), .reset(reset), .ch_req(ch_req_l), .ch_we(ch_we_l), .ch_addr(ch_addr_l),
    .ch_wdata(ch_wdata_l), .ch_ack(ch_ack_l), .ch_rdata(ch_rdata_l), .grant_idx(grant_idx_l),
    .busy(busy_l), .data_from_mem(data_from_mem_l), .mem_address(mem_address_l),
    .data_to_mem_store(data_to_mem_store_l), .write_to_memory(write_to_memory_l),
    .reading_for_load(reading_for_load_l)
  );

  function automatic logic [W-1:0] init_val(input logic [7:0] a);
    return (a == 8'h40) ? 16'hBEEF : {8'hC5, a};
  endfunction

  // Memory model: one-cycle read for dut, three-cycle read pipe for dut_l.
  logic [W-1:0] mem [256];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(8'(i));
    end else if (write_to_memory) begin
      mem[mem_address[7:0]] <= data_to_mem_store;
    end
    data_from_mem   <= mem[mem_address[7:0]];
    d1_l            <= mem[mem_address_l[7:0]];
    d2_l            <= d1_l;
    data_from_mem_l <= d2_l;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0] ref_mem [256];

  typedef struct {
    int           ch;
    int           cyc;
    logic [W-1:0] rdata;
  } exp_t;
  exp_t sbq[$];

  int n_checks = 0;
  int n_errors = 0;
  int remaining [N];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_ack(input int ch, input int c, input logic [W-1:0] rd);
    exp_t e;
    e.ch = ch; e.cyc = c; e.rdata = rd;
    sbq.push_back(e);
  endtask

  task automatic set_ch(input int c, input logic we, input logic [AB-1:0] a, input logic [W-1:0] d);
    ch_we[c]             = we;
    ch_addr[c*AB +: AB]  = a;
    ch_wdata[c*W +: W]   = d;
    ch_req[c]            = 1'b1;
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (ch_ack !== '0) begin
        if (sbq.size() == 0) begin
          check("spurious_ack", 32'(ch_ack), 32'd0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("ack_onehot", 32'(ch_ack), 32'(1) << e.ch);
          check("ack_cycle", cyc, e.cyc);
          check("ack_grant", 32'(grant_idx), e.ch);
          check("ack_rdata", 32'(ch_rdata), 32'(e.rdata));
        end
      end else begin
        check("rdata_idle", 32'(ch_rdata), 32'd0);
      end
    end
  endtask

  // Waits for the scoreboard to empty, releasing each requester after its
  // last expected ack.
  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
      for (int c = 0; c < N; c++) begin
        if (ch_ack[c]) begin
          remaining[c]--;
          if (remaining[c] <= 0) ch_req[c] = 1'b0;
        end
      end
    end
    check("drain_timeout", sbq.size(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1);
  end

  initial begin
    int t0;
    int order [6];
    logic [AB-1:0] ch_a [N];
    reset = 1'b1; mem_init = 1'b1;
    ch_req = '0; ch_we = '0; ch_addr = '0; ch_wdata = '0;
    ch_req_l = '0; ch_we_l = '0; ch_addr_l = '0; ch_wdata_l = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
    repeat (3) @(negedge clk);

    check("rst_ack", 32'(ch_ack), 0);
    check("rst_rdata", 32'(ch_rdata), 0);
    check("rst_grant", 32'(grant_idx), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_addr", 32'(mem_address), 0);
    check("rst_wdata", 32'(data_to_mem_store), 0);
    check("rst_we", 32'(write_to_memory), 0);
    check("rst_re", 32'(reading_for_load), 0);
    check("rst_ack_l", 32'(ch_ack_l), 0);
    reset = 1'b0; mem_init = 1'b0;
    fork monitor(); join_none
    @(negedge clk);

    // Single read on ch0.
    t0 = cyc;
    set_ch(0, 1'b0, 16'h0040, 16'h0);
    remaining[0] = 1;
    expect_ack(0, t0 + 2, ref_mem[8'h40]);
    @(negedge clk);
    check("rd_addr", 32'(mem_address), 32'h0040);
    check("rd_re", 32'(reading_for_load), 1);
    check("rd_we", 32'(write_to_memory), 0);
    check("rd_busy", 32'(busy), 1);
    drain(20);

    // Single write on ch1; later changes to addr/data must be ignored.
    t0 = cyc;
    set_ch(1, 1'b1, 16'h0100, 16'h1234);
    expect_ack(1, t0 + 2, 16'h0);
    ref_mem[8'h00] = 16'h1234;
    @(negedge clk);
    check("wr_we_c1", 32'(write_to_memory), 1);
    check("wr_re_c1", 32'(reading_for_load), 0);
    check("wr_addr_c1", 32'(mem_address), 32'h0100);
    check("wr_data_c1", 32'(data_to_mem_store), 32'h1234);
    ch_addr[1*AB +: AB] = 16'h0077;
    ch_wdata[1*W +: W]  = 16'hDEAD;
    @(negedge clk);
    check("wr_we_c2", 32'(write_to_memory), 0);
    check("wr_re_c2", 32'(reading_for_load), 0);
    check("wr_addr_c2", 32'(mem_address), 32'h0100);
    check("wr_data_c2", 32'(data_to_mem_store), 32'h1234);
    ch_req[1] = 1'b0;
    drain(20);

    // Read-back on ch2 with the request dropped right after the grant.
    t0 = cyc;
    set_ch(2, 1'b0, 16'h0100, 16'h0);
    expect_ack(2, t0 + 2, ref_mem[8'h00]);
    @(negedge clk);
    ch_req[2] = 1'b0;
    drain(20);

    // Three-way contention, every request held.
    ch_a[0] = 16'h0040; ch_a[1] = 16'h0021; ch_a[2] = 16'h0022;
    t0 = cyc;
    for (int c = 0; c < N; c++) set_ch(c, 1'b0, ch_a[c], 16'h0);
`ifdef MEM_ARB_FIXED_PRIO_EN
    order = '{0, 0, 0, 0, 0, 0};
    remaining = '{6, 99, 99};
`else
    order = '{0, 1, 2, 0, 1, 2};
    remaining = '{2, 2, 2};
`endif
    for (int k = 0; k < 6; k++) expect_ack(order[k], t0 + 2 + 3 * k, ref_mem[ch_a[order[k]][7:0]]);
    drain(60);
    ch_req = '0;
    @(negedge clk);

    // ch0 and ch2 held for four transaction slots.
    t0 = cyc;
    set_ch(0, 1'b0, 16'h0040, 16'h0);
    set_ch(2, 1'b0, 16'h0022, 16'h0);
`ifdef MEM_ARB_FIXED_PRIO_EN
    order = '{0, 0, 0, 0, 0, 0};
    remaining = '{4, 0, 99};
`else
    order = '{0, 2, 0, 2, 0, 0};
    remaining = '{2, 0, 2};
`endif
    for (int k = 0; k < 4; k++) expect_ack(order[k], t0 + 2 + 3 * k, ref_mem[ch_a[order[k]][7:0]]);
    drain(40);
    ch_req = '0;
    @(negedge clk);

    // Reset during the access cycle of a ch0 read, then ch0 vs ch1.
    set_ch(0, 1'b0, 16'h0040, 16'h0);
    @(negedge clk);
    reset = 1'b1;
    ch_req = '0;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_ack", 32'(ch_ack), 0);
    check("mid_rst_we", 32'(write_to_memory), 0);
    check("mid_rst_re", 32'(reading_for_load), 0);
    check("mid_rst_addr", 32'(mem_address), 0);
    t0 = cyc;
    set_ch(1, 1'b0, 16'h0021, 16'h0);
    set_ch(0, 1'b0, 16'h0023, 16'h0);
    remaining = '{1, 1, 0};
    expect_ack(0, t0 + 2, ref_mem[8'h23]);
    expect_ack(1, t0 + 5, ref_mem[8'h21]);
    drain(30);
    ch_req = '0;
    @(negedge clk);

    // Latency-3 instance: read on ch2, address changed after the grant.
    t0 = cyc;
    ch_we_l[2] = 1'b0;
    ch_addr_l[2*AB +: AB] = 16'h0040;
    ch_req_l[2] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) ch_addr_l[2*AB +: AB] = 16'h0099;
      check("l3_cycle", cyc, t0 + k);
      check("l3_addr", 32'(mem_address_l), 32'h0040);
      check("l3_re", 32'(reading_for_load_l), (k <= 3) ? 1 : 0);
      check("l3_ack", 32'(ch_ack_l), (k == 4) ? 32'b100 : 0);
      check("l3_rdata", 32'(ch_rdata_l), (k == 4) ? 32'(ref_mem[8'h40]) : 0);
    end
    ch_req_l = '0;
    @(negedge clk);
    check("l3_ack_after", 32'(ch_ack_l), 0);
    check("l3_busy_after", 32'(busy_l), 0);

    repeat (2) @(negedge clk);
    check("sb_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Parametrised multi-channel memory port for the CPU. Lets NUM_CH requesters (instruction fetch, load/store, I/O or display engine) share the one single-port memory that the CPU top currently drives alone.
- Round-robin arbitration, request/acknowledge handshake per channel, configurable synchronous-memory read latency.
- The memory-side signal names match the existing CPU memory interface, so the block drops in between the core(s) and memory.

Parameters:
- WIDTH, 16, data word width in bits.
- ADDR_BITS, 16, memory address width in bits.
- NUM_CH, 2, number of requesting channels (>=2).
- MEM_LATENCY, 1, cycles from address presented to data_from_mem valid (>=1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- ch_req  in  NUM_CH  per-channel request, held until that channel's ack.
- ch_we  in  NUM_CH  per-channel write (1) / read (0).
- ch_addr  in  NUM_CH*ADDR_BITS  packed addresses; channel i at [i*ADDR_BITS +: ADDR_BITS].
- ch_wdata  in  NUM_CH*WIDTH  packed store data; channel i at [i*WIDTH +: WIDTH].
- ch_ack  out  NUM_CH  one-cycle completion pulse, one-hot.
- ch_rdata  out  WIDTH  shared read data; valid only while a ch_ack bit is high for a read.
- grant_idx  out  max(1,clog2(NUM_CH))  channel currently or last served.
- busy  out  1  high when not IDLE.
- data_from_mem  in  WIDTH  memory read data.
- mem_address  out  ADDR_BITS  memory address.
- data_to_mem_store  out  WIDTH  memory write data.
- write_to_memory  out  1  memory write strobe.
- reading_for_load  out  1  memory read enable.

Behaviour:
- Reset values: all outputs 0; state IDLE; RR pointer 0; latency counter 0.
- FSM states:
  - IDLE:
    - If any ch_req is set, select a winner by round-robin: first set bit searching upward from the pointer, wrapping at NUM_CH.
    - Latch the winner's addr, wdata, we and index into internal registers; go to ACCESS.
    - Set pointer = (winner+1) mod NUM_CH.
    - If no request is set, stay in IDLE.
  - ACCESS (MEM_LATENCY cycles, counted down):
    - mem_address and data_to_mem_store come from the latched registers.
    - Write: write_to_memory=1 in the first ACCESS cycle only.
    - Read: reading_for_load=1 in every ACCESS cycle.
    - After the last ACCESS cycle, go to RESP.
  - RESP (1 cycle):
    - ch_ack[grant]=1.
    - ch_rdata = data_from_mem (pass-through) for reads.
    - Address and data stay held.
    - Next state is IDLE.
- Latency: request first seen in IDLE at cycle 0 → ack at cycle MEM_LATENCY+1. Back-to-back period is MEM_LATENCY+2 cycles.
- Reads and writes use identical timing.
- Latched request: requester changes to addr, wdata or we after the grant have no effect.
- Dropped request: if ch_req is dropped after the grant, the transaction still completes and acks.
- Back-to-back from one channel: the requester may hold ch_req high through ack with new addr/we; the next IDLE treats it as a new request.
- IDLE outputs: write_to_memory=0 and reading_for_load=0; mem_address and data_to_mem_store hold their last values.
- Outside RESP: ch_ack=0 and ch_rdata=0.
- grant_idx updates on grant and holds through IDLE.
- Simultaneous requests: exactly one grant per IDLE cycle; requests that lose are held, never lost.
- Reset mid-transaction: next cycle IDLE, strobes 0, no ack issued, pointer 0.

Optional Feature:
- Macro: MEM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; pointer register removed. Starvation of high-index channels is permitted.
- Undefined: round-robin as specified above.

Decomposition:
- Package mem_arb_pkg:
  - state enum IDLE/ACCESS/RESP;
  - function ch_idx_bits(NUM_CH) returning max(1,clog2);
  - latency counter width constant derived from MEM_LATENCY.
- Sub-module rr_pick:
  - parametrised NUM_CH;
  - inputs: request vector, pointer;
  - outputs: winner index, any_req;
  - combinational;
  - MEM_ARB_FIXED_PRIO_EN selects the priority encoder variant inside it.
- FSM, latching registers and counter live in mem_arbiter.

Test Plan:
- Single read (NUM_CH=3, MEM_LATENCY=1): ch_req[0], addr 0x0040, memory returns 0xBEEF → cycle 1 mem_address=0x0040 and reading_for_load=1; cycle 2 ch_ack=3'b001 and ch_rdata=0xBEEF.
- Single write: ch1 write, addr 0x0100, data 0x1234 → write_to_memory high only in cycle 1, data_to_mem_store=0x1234 through cycle 2, ch_ack=3'b010 in cycle 2, reading_for_load never high.
- Contention: all three ch_req held high continuously → grant order 0,1,2,0,1; acks at cycles 2,5,8,11,14.
- Long latency: MEM_LATENCY=3 read on ch2 → reading_for_load high cycles 1–3, ch_ack[2] at cycle 4, ch_rdata equals data_from_mem in cycle 4; changing ch_addr after cycle 0 does not change mem_address.
- Reset mid-access: reset pulsed in ACCESS cycle 1 → next cycle busy=0, no ack, strobes 0; with ch1 and ch0 requesting afterwards, ch0 is granted first (pointer 0).
- Fixed priority: with MEM_ARB_FIXED_PRIO_EN and ch0, ch2 both held high for 12 cycles → only ch0 is acked (4 acks), ch2 receives none.
